// File: rtl/psram_port_arbiter.sv
// Three-port scheduler in front of the PSRAM controller: port 0 (video read) has
// priority bounded by a run limit, ports 1/2 share a round-robin slot.
module psram_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int P0_MAX_RUN = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrlr_good,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic              p0_burst,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_op_begun,
    output logic              p0_data_ok,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic              p1_burst,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_op_begun,
    output logic              p1_data_ok,
    input  logic              p2_req,
    input  logic              p2_wr,
    input  logic              p2_burst,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p2_op_begun,
    output logic              p2_data_ok,
    input  logic              op_begun,
    input  logic              data_ok,
    input  logic              op_finished,
    output logic [ADDR_W-1:0] app_addr,
    output logic [DATA_W-1:0] app_data_out,
    output logic              app_wr,
    output logic              app_rd,
    output logic              app_burst,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int               RUN_W    = $clog2(P0_MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(P0_MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0]       NO_OWNER = 2'd3;

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          owner_r;
    logic [1:0]          rr_ptr_r;
    logic [RUN_W-1:0]    run_r;
    logic [7:0]          tmo_r;
    logic                err_r;
    logic [ADDR_W-1:0]   app_addr_r;
    logic [DATA_W-1:0]   app_data_r;
    logic                app_wr_r;
    logic                app_rd_r;
    logic                app_burst_r;

    logic                other_req_s;
    logic                any_req_s;
    logic                p0_wins_s;
    logic [1:0]          rr_pick_s;
    logic [1:0]          winner_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   data_s;
    logic                wr_s;
    logic                burst_s;
    logic                grant_s;
    logic                begin_s;
    logic                abort_s;
    logic                release_s;
    logic                dok_s;

    // Winner selection: port 0 unless its run limit is reached while 1/2 wait.
    always_comb begin
        other_req_s = p1_req | p2_req;
        any_req_s   = p0_req | other_req_s;
        if (p1_req && p2_req) begin
            rr_pick_s = rr_ptr_r;
        end else if (p1_req) begin
            rr_pick_s = 2'd1;
        end else begin
            rr_pick_s = 2'd2;
        end
        p0_wins_s = p0_req && !((run_r == RUN_MAX) && other_req_s);
        if (p0_wins_s) begin
            winner_s = 2'd0;
        end else begin
            winner_s = rr_pick_s;
        end
    end

    // Operand mux for the winning port; port 0 is read-only whatever p0_wr says.
    always_comb begin
        case (winner_s)
            2'd0: begin
                addr_s  = p0_addr;
                data_s  = {DATA_W{1'b0}};
                wr_s    = p0_wr & 1'b0;
                burst_s = p0_burst;
            end
            2'd1: begin
                addr_s  = p1_addr;
                data_s  = p1_wdata;
                wr_s    = p1_wr;
                burst_s = p1_burst;
            end
            2'd2: begin
                addr_s  = p2_addr;
                data_s  = p2_wdata;
                wr_s    = p2_wr;
                burst_s = p2_burst;
            end
            default: begin
                addr_s  = {ADDR_W{1'b0}};
                data_s  = {DATA_W{1'b0}};
                wr_s    = 1'b0;
                burst_s = 1'b0;
            end
        endcase
    end

    // Next-state logic and the per-cycle events it implies.
    always_comb begin
        state_s   = state_r;
        grant_s   = 1'b0;
        begin_s   = 1'b0;
        abort_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrlr_good && any_req_s) begin
                    grant_s = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_begun) begin
                    begin_s = 1'b1;
                    if (op_finished) begin
                        release_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_ACTIVE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ACTIVE: begin
                if (op_finished) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Ownership and controller-facing strobes; operand fields hold after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r     <= NO_OWNER;
            app_addr_r  <= {ADDR_W{1'b0}};
            app_data_r  <= {DATA_W{1'b0}};
            app_wr_r    <= 1'b0;
            app_rd_r    <= 1'b0;
            app_burst_r <= 1'b0;
        end else if (grant_s) begin
            owner_r     <= winner_s;
            app_addr_r  <= addr_s;
            app_data_r  <= data_s;
            app_wr_r    <= wr_s;
            app_rd_r    <= ~wr_s;
            app_burst_r <= burst_s;
        end else begin
            if (begin_s || abort_s) begin
                app_wr_r <= 1'b0;
                app_rd_r <= 1'b0;
            end
            if (release_s || abort_s) begin
                owner_r <= NO_OWNER;
            end
        end
    end

    // Strobe timeout counter and the sticky error it raises.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= 8'd0;
            err_r <= 1'b0;
        end else begin
            if ((state_r == ST_ISSUE) && !begin_s && !abort_s) begin
                tmo_r <= tmo_r + 8'd1;
            end else begin
                tmo_r <= 8'd0;
            end
            if (abort_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Port-0 run length (only meaningful while 1/2 wait) and 1/2 round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_r    <= {RUN_W{1'b0}};
            rr_ptr_r <= 2'd1;
        end else if (grant_s && (winner_s != 2'd0)) begin
            run_r    <= {RUN_W{1'b0}};
            rr_ptr_r <= (winner_s == 2'd1) ? 2'd2 : 2'd1;
        end else if (!other_req_s) begin
            run_r <= {RUN_W{1'b0}};
        end else if (grant_s && (run_r != RUN_MAX)) begin
            run_r <= run_r + RUN_ONE;
        end
    end

    assign dok_s = (state_r == ST_ACTIVE) && data_ok;

    // Route controller handshakes to the owning port only.
    always_comb begin
        p0_op_begun = 1'b0;
        p1_op_begun = 1'b0;
        p2_op_begun = 1'b0;
        p0_data_ok  = 1'b0;
        p1_data_ok  = 1'b0;
        p2_data_ok  = 1'b0;
        case (owner_r)
            2'd0: begin
                p0_op_begun = begin_s;
                p0_data_ok  = dok_s;
            end
            2'd1: begin
                p1_op_begun = begin_s;
                p1_data_ok  = dok_s;
            end
            2'd2: begin
                p2_op_begun = begin_s;
                p2_data_ok  = dok_s;
            end
            default: begin
                p0_op_begun = 1'b0;
                p0_data_ok  = 1'b0;
            end
        endcase
    end

    assign app_addr     = app_addr_r;
    assign app_data_out = app_data_r;
    assign app_wr       = app_wr_r;
    assign app_rd       = app_rd_r;
    assign app_burst    = app_burst_r;
    assign owner        = owner_r;
    assign timeout_err  = err_r;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_psram_port_arbiter;
    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 16;
    localparam int P0_MAX_RUN = 4;
    localparam int TIMEOUT    = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, ctrlr_good;
    logic [2:0]        req, wr, burst;
    logic [ADDR_W-1:0] addr [3];
    logic [DATA_W-1:0] wdata [3];
    logic              op_begun, data_ok, op_finished;
    logic [2:0]        pob, pdok;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_data_out;
    logic              app_wr, app_rd, app_burst, timeout_err;
    logic [1:0]        owner;

    psram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .P0_MAX_RUN(P0_MAX_RUN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ctrlr_good(ctrlr_good),
        .p0_req(req[0]), .p0_wr(wr[0]), .p0_burst(burst[0]), .p0_addr(addr[0]),
        .p0_op_begun(pob[0]), .p0_data_ok(pdok[0]),
        .p1_req(req[1]), .p1_wr(wr[1]), .p1_burst(burst[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_op_begun(pob[1]), .p1_data_ok(pdok[1]),
        .p2_req(req[2]), .p2_wr(wr[2]), .p2_burst(burst[2]), .p2_addr(addr[2]), .p2_wdata(wdata[2]),
        .p2_op_begun(pob[2]), .p2_data_ok(pdok[2]),
        .op_begun(op_begun), .data_ok(data_ok), .op_finished(op_finished),
        .app_addr(app_addr), .app_data_out(app_data_out), .app_wr(app_wr), .app_rd(app_rd),
        .app_burst(app_burst), .owner(owner), .timeout_err(timeout_err)
    );

    // reference model: who owns the controller and whether the strobe is still presented
    int                m_owner, m_wait, m_run, m_rr;
    bit                m_pres, m_err, m_wr, m_burst, m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    // stimulus configuration
    int rate [3];
    int left [3];
    int wr_sel [3];
    bit drop [3];
    bit fix_addr, rnd, ctl_single;
    int ctl_delay, ctl_ndata, ip_cnt;

    // observations taken from the DUT
    int                grants[$];
    int                runs[$];
    int                cur_run, rd_cyc, wr_cyc, p0b_cnt, p0d_cnt, prev_owner;
    logic [ADDR_W-1:0] first_addr;

    int total = 0;
    int bad   = 0;
    int exp3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int gq(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    function automatic int pick();
        bit other;
        other = req[1] | req[2];
        if (req[0] && !(m_run == P0_MAX_RUN && other)) return 0;
        if (req[1] && req[2]) return m_rr;
        return req[1] ? 1 : 2;
    endfunction

    task automatic clear_stats();
        grants.delete();
        runs.delete();
        cur_run = 0; rd_cyc = 0; wr_cyc = 0; p0b_cnt = 0; p0d_cnt = 0;
        prev_owner = m_owner;
        first_addr = '0;
    endtask

    // drive requesters and the controller for the coming cycle
    task automatic drive();
        for (int n = 0; n < 3; n++) begin
            if (drop[n]) begin
                req[n] = 1'b0;
                drop[n] = 1'b0;
            end
        end
        for (int n = 0; n < 3; n++) begin
            if (!req[n] && left[n] > 0 && $urandom_range(0, 99) < rate[n]) begin
                req[n]   = 1'b1;
                left[n]  = left[n] - 1;
                addr[n]  = fix_addr ? 23'h000100 : 23'($urandom);
                wdata[n] = 16'($urandom);
                burst[n] = fix_addr ? 1'b1 : 1'($urandom);
                wr[n]    = (wr_sel[n] == 2) ? 1'($urandom) : wr_sel[n][0];
            end
        end
        op_begun = 1'b0; op_finished = 1'b0; data_ok = 1'b0;
        if (rnd && $urandom_range(0, 39) == 0) ctrlr_good = !ctrlr_good;
        if (m_owner != 3 && m_pres) begin
            if (ctl_delay != 0 && m_wait + 1 >= ctl_delay) begin
                op_begun    = 1'b1;
                op_finished = ctl_single;
            end
            if (rnd) data_ok = 1'($urandom);
        end else if (m_owner != 3) begin
            if (rnd) begin
                data_ok     = 1'($urandom);
                op_finished = ($urandom_range(0, 4) == 0);
            end else if (ip_cnt < ctl_ndata) begin
                data_ok = 1'b1;
            end else begin
                op_finished = 1'b1;
            end
        end else if (rnd) begin
            data_ok = 1'($urandom);
        end
    endtask

    // compare DUT outputs with the model for the current cycle and gather observations
    task automatic compare();
        if (!m_valid) return;
        chk("owner", owner, m_owner);
        chk("app_rd", app_rd, m_pres && !m_wr);
        chk("app_wr", app_wr, m_pres && m_wr);
        chk("timeout_err", timeout_err, m_err);
        chk("app_addr", app_addr, m_addr);
        chk("app_burst", app_burst, m_burst);
        if (m_pres && m_wr) chk("app_data_out", app_data_out, m_data);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("p%0d_op_begun", n), pob[n], m_pres && op_begun && m_owner == n);
            chk($sformatf("p%0d_data_ok", n), pdok[n], m_owner == n && !m_pres && data_ok);
        end
        if (app_rd) rd_cyc++;
        if (app_wr) wr_cyc++;
        if (app_rd || app_wr) begin
            cur_run++;
        end else if (cur_run > 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
        if (prev_owner == 3 && owner != 2'd3) begin
            grants.push_back(int'(owner));
            if (grants.size() == 1) first_addr = app_addr;
        end
        prev_owner = int'(owner);
        p0b_cnt += int'(pob[0]);
        p0d_cnt += int'(pdok[0]);
    endtask

    // advance the model by the edge that samples this cycle's inputs
    task automatic step();
        bit other;
        int w;
        other = req[1] | req[2];
        if (reset) begin
            m_owner = 3; m_pres = 0; m_wait = 0; m_run = 0; m_rr = 1; m_err = 0;
            m_addr = '0; m_data = '0; m_wr = 0; m_burst = 0; ip_cnt = 0; m_valid = 1;
        end else begin
            if (m_owner == 3) begin
                if (ctrlr_good && (req != 3'b000)) begin
                    w = pick();
                    if (w == 0) begin
                        if (other && m_run < P0_MAX_RUN) m_run++;
                    end else begin
                        m_run = 0;
                        m_rr  = (w == 1) ? 2 : 1;
                    end
                    m_owner = w; m_pres = 1; m_wait = 0;
                    m_addr = addr[w]; m_data = wdata[w]; m_burst = burst[w];
                    m_wr = (w != 0) && wr[w];
                    if (rnd) begin
                        ctl_delay  = $urandom_range(1, 4);
                        ctl_single = ($urandom_range(0, 3) == 0);
                    end
                end
            end else if (m_pres) begin
                m_wait++;
                if (op_begun) begin
                    m_pres = 0;
                    drop[m_owner] = 1'b1;
                    ip_cnt = 0;
                    if (op_finished) m_owner = 3;
                end else if (m_wait == TIMEOUT) begin
                    m_pres = 0; m_owner = 3; m_err = 1;
                end
            end else begin
                ip_cnt++;
                if (op_finished) m_owner = 3;
            end
            if (!other) m_run = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            compare();
            step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; ctrlr_good = 1'b0; req = '0; wr = '0; burst = '0;
        op_begun = 1'b0; data_ok = 1'b0; op_finished = 1'b0;
        for (int n = 0; n < 3; n++) begin
            addr[n] = '0; wdata[n] = '0; rate[n] = 0; left[n] = 0; wr_sel[n] = 0; drop[n] = 0;
        end
        fix_addr = 0; rnd = 0; ctl_single = 0; ctl_delay = 2; ctl_ndata = 1; ip_cnt = 0;
        m_valid = 0; m_owner = 3; m_pres = 0; m_wait = 0; m_run = 0; m_rr = 1; m_err = 0;
        m_wr = 0; m_burst = 0; m_addr = '0; m_data = '0;
        clear_stats();
        @(posedge clk);
        #1;
        run(2);
        chk("reset_owner", owner, 3);
        chk("reset_strobes", {app_rd, app_wr}, 0);
        chk("reset_err", timeout_err, 0);
        chk("reset_addr", app_addr, 0);
        reset = 1'b0; ctrlr_good = 1'b1;

        // port 0 alone, burst read at 0x000100
        clear_stats();
        fix_addr = 1; rate[0] = 100; left[0] = 1; ctl_delay = 3; ctl_ndata = 4;
        run(15);
        chk("ph1_strobe_runs", runs.size(), 1);
        chk("ph1_rd_len", (runs.size() > 0) ? runs[0] : -1, 3);
        chk("ph1_wr_cycles", wr_cyc, 0);
        chk("ph1_p0_op_begun_pulses", p0b_cnt, 1);
        chk("ph1_p0_data_ok_pulses", p0d_cnt, 4);
        chk("ph1_grant", gq(0), 0);
        chk("ph1_addr", first_addr, 32'h100);
        chk("ph1_owner_end", owner, 3);
        fix_addr = 0;

        // ports 1 and 2 writing continuously
        clear_stats();
        rate[1] = 100; rate[2] = 100; left[1] = 1000; left[2] = 1000;
        wr_sel[1] = 1; wr_sel[2] = 1; ctl_delay = 2; ctl_ndata = 2;
        run(40);
        for (int i = 0; i < 4; i++) chk($sformatf("ph2_grant%0d", i), gq(i), (i % 2 == 0) ? 1 : 2);
        chk("ph2_rd_cycles", rd_cyc, 0);
        chk("ph2_wr_used", wr_cyc > 0, 1);
        left[1] = 0; left[2] = 0;
        run(60);

        // port 0 and port 1 continuous: run limit forces port 1 in
        clear_stats();
        rate[0] = 100; rate[1] = 100; left[0] = 1000; left[1] = 1000; ctl_delay = 1; ctl_ndata = 1;
        run(80);
        for (int i = 0; i < 10; i++) chk($sformatf("ph3_grant%0d", i), gq(i), exp3[i]);
        left[0] = 0; left[1] = 0;
        run(60);

        // controller never accepts: strobe timeout and re-grant
        clear_stats();
        rate[0] = 100; left[0] = 1; ctl_delay = 0;
        run(262);
        chk("ph4_strobe_len", (runs.size() > 0) ? runs[0] : -1, TIMEOUT);
        chk("ph4_err_set", timeout_err, 1);
        chk("ph4_first_grant", gq(0), 0);
        chk("ph4_regrant", gq(1), 0);
        ctl_delay = 2; ctl_ndata = 1;
        run(20);
        chk("ph4_err_sticky", timeout_err, 1);
        chk("ph4_owner_end", owner, 3);

        // controller not ready: nothing granted until ctrlr_good returns
        clear_stats();
        ctrlr_good = 1'b0;
        for (int n = 0; n < 3; n++) begin rate[n] = 100; left[n] = 1; end
        wr_sel[1] = 1; wr_sel[2] = 0;
        run(10);
        chk("ph5_no_grants", grants.size(), 0);
        chk("ph5_no_strobes", rd_cyc + wr_cyc, 0);
        chk("ph5_owner", owner, 3);
        ctrlr_good = 1'b1;
        run(1);
        chk("ph5_first_owner", owner, 0);
        chk("ph5_first_rd", app_rd, 1);
        run(60);
        chk("ph5_served", grants.size(), 3);

        // reset in the middle of a port-1 write
        clear_stats();
        rate[1] = 100; left[1] = 1; wr_sel[1] = 1; ctl_delay = 1; ctl_ndata = 20;
        run(5);
        chk("ph6_active_owner", owner, 1);
        chk("ph6_active_strobe", app_wr, 0);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        chk("ph6_rst_strobes", {app_rd, app_wr}, 0);
        chk("ph6_rst_owner", owner, 3);
        chk("ph6_rst_err", timeout_err, 0);
        clear_stats();
        rate[1] = 100; rate[2] = 100; left[1] = 1; left[2] = 1; wr_sel[2] = 1; ctl_ndata = 1;
        run(10);
        chk("ph6_ptr_port1", gq(0), 1);
        run(40);

        // random traffic with random controller timing and ctrlr_good glitches
        clear_stats();
        rnd = 1;
        for (int n = 0; n < 3; n++) begin
            rate[n] = $urandom_range(20, 60); left[n] = 100000; wr_sel[n] = 2;
        end
        run(3000);
        rnd = 0; ctrlr_good = 1'b1; ctl_delay = 2; ctl_ndata = 1;
        for (int n = 0; n < 3; n++) left[n] = 0;
        run(80);
        chk("ph7_activity", grants.size() > 50, 1);
        chk("ph7_drained_owner", owner, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psram_port_arbiter.md
Name: psram_port_arbiter

Overview:
- Three-requester arbiter/scheduler in front of the PSRAM controller, in the memory clock domain (app_clk_100).
- Port 0 is the video-pipeline read port: priority, deadline-critical.
- Port 1 is the camera write port. Port 2 is an auxiliary read/write port (overlay/debug).
- Grants one whole operation (single or burst) at a time, holds the controller strobes until op_begun, routes op_begun/data_ok back only to the owner, and releases on op_finished. Anti-starvation and strobe-timeout protection included.

Parameters:
- ADDR_W, 23, address width.
- DATA_W, 16, data width.
- P0_MAX_RUN, 4, max consecutive port-0 grants while port 1 or 2 is pending.
- TIMEOUT, 255, cycles allowed from strobe assertion to op_begun before abort (8-bit counter).

Ports:
- clk  in  1  memory-domain clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- ctrlr_good  in  1  controller initialised; no grants while low
- pN_req  in  1  request from port N (N=0,1,2); held until pN_op_begun
- pN_wr  in  1  1=write, 0=read (port 0 tied 0 externally; ignored for port 0)
- pN_burst  in  1  burst operation
- pN_addr  in  ADDR_W  address
- pN_wdata  in  DATA_W  write data (ports 1,2)
- pN_op_begun  out  1  one-cycle pulse: owner's op accepted
- pN_data_ok  out  1  data_ok forwarded to owner only
- op_begun  in  1  from controller
- data_ok  in  1  from controller
- op_finished  in  1  from controller
- app_addr  out  ADDR_W  to controller
- app_data_out  out  DATA_W  to controller
- app_wr  out  1  write strobe
- app_rd  out  1  read strobe
- app_burst  out  1  burst flag
- owner  out  2  current owner (3 = none)
- timeout_err  out  1  sticky; set on strobe timeout, cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0, except owner=3.
  - FSM=IDLE; run counter=0; round-robin pointer=port 1; timeout counter=0.
- FSM states: IDLE, ISSUE, ACTIVE.
- IDLE:
  - If ctrlr_good and any req: choose winner, register its addr/wdata/wr/burst into app_* outputs, set owner, go to ISSUE.
  - The strobe (app_wr or app_rd) asserts in the cycle after the req is sampled, so decision latency = 1 cycle.
- Arbitration:
  - Port 0 wins, unless run counter == P0_MAX_RUN and port 1 or 2 is requesting; in that case the 1/2 round-robin winner takes the slot.
  - Between ports 1 and 2: round-robin. The pointer toggles to the other port after each grant to 1 or 2.
  - Run counter:
    - increments on each port-0 grant while another port is pending (saturating);
    - clears on any grant to 1 or 2;
    - clears when no other port is pending.
- ISSUE:
  - Strobe and app_* values are held stable.
  - On op_begun: deassert strobe the same edge, pulse pN_op_begun for the owner, go to ACTIVE.
  - Timeout counter increments each ISSUE cycle. On reaching TIMEOUT without op_begun: drop strobe, set timeout_err, owner=3, go to IDLE. The request stays pending and is re-arbitrated.
- ACTIVE:
  - data_ok is forwarded combinationally to pN_data_ok of the owner; all other ports see 0.
  - On op_finished: owner=3, go to IDLE. A new grant may be decided in that same IDLE cycle, giving one idle cycle between operations.
- Ownership rules:
  - pN_data_ok and pN_op_begun are never asserted for a non-owner.
  - app_rd and app_wr are never high together.
- A req drop in ISSUE before op_begun is ignored: the operation completes, and the arbiter never cancels a presented strobe except on timeout.
- ctrlr_good falling mid-operation: the current operation proceeds; no new grants until ctrlr_good returns high.
- Simultaneous op_begun and op_finished in ISSUE (single-cycle op): pulse op_begun and return directly to IDLE.
- Reset mid-operation: immediate return to reset values on the next clk edge.
- Port 0 write request (p0_wr=1): treated as a read; app_rd is used.

Test Plan:
- Port 0 alone, burst read at 0x000100; controller returns op_begun 3 cycles later, then 4 data_ok, then op_finished -> app_rd high exactly 3 cycles, p0_op_begun single pulse, p0_data_ok pulses=4, owner 0→3.
- Ports 1 and 2 requesting continuously, port 0 idle -> grants alternate 1,2,1,2; p1 app_data_out=p1_wdata during p1 ops; app_wr used, app_rd never high.
- Port 0 continuous and port 1 continuous, P0_MAX_RUN=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1…
- Controller never asserts op_begun, TIMEOUT=255 -> strobe drops after 255 ISSUE cycles, timeout_err=1 and stays 1, FSM back to IDLE, request re-granted.
- ctrlr_good=0 with all reqs high -> owner stays 3, no strobes; raise ctrlr_good -> port 0 granted one cycle later.
- Assert reset during ACTIVE of a port 1 write -> next cycle all strobes 0, owner=3, timeout_err=0, pointer=port 1.
